piradspi_core: RTL and testbench

SPI master with AXI4-Lite control/status register (CSR) slave, one clock domain. Software writes per-target "profiles" (clock divider, CPOL/CPHA, length, target select), loads TX data, then issues a command naming a profile. The block runs one MSB-first transfer of 1..64 bits and captures the received data into read-only registers. Sits between the processor AXI-Lite interconnect and off-chip SPI slaves.

---
 rtl/piradspi_core.sv | 187 ++++++++++++++++++
 tb/tb_piradspi_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piradspi_core.sv
// piradspi_core: SPI master behind an AXI4-Lite CSR slave; profiles pick divider, mode, length and target.
// Optional PIRADSPI_LOOPBACK_EN: STATUS bit2 routes mosi back into the receive shifter instead of miso.
module piradspi_core #(
  parameter int C_SPI_SEL_MODE   = 1,
  parameter int C_CSR_DATA_WIDTH = 32,
  parameter int C_CSR_ADDR_WIDTH = 8,
  parameter int C_SPI_SEL_WIDTH  = 5,
  parameter int C_NUM_PROFILES   = 16
) (
  input  logic                          csr_aclk,
  input  logic                          csr_areset,
  input  logic [C_CSR_ADDR_WIDTH-1:0]   csr_awaddr,
  input  logic [2:0]                    csr_awprot,
  input  logic                          csr_awvalid,
  output logic                          csr_awready,
  input  logic [C_CSR_DATA_WIDTH-1:0]   csr_wdata,
  input  logic [C_CSR_DATA_WIDTH/8-1:0] csr_wstrb,
  input  logic                          csr_wvalid,
  output logic                          csr_wready,
  output logic [1:0]                    csr_bresp,
  output logic                          csr_bvalid,
  input  logic                          csr_bready,
  input  logic [C_CSR_ADDR_WIDTH-1:0]   csr_araddr,
  input  logic [2:0]                    csr_arprot,
  input  logic                          csr_arvalid,
  output logic                          csr_arready,
  output logic [C_CSR_DATA_WIDTH-1:0]   csr_rdata,
  output logic [1:0]                    csr_rresp,
  output logic                          csr_rvalid,
  input  logic                          csr_rready,
  output logic                          sclk,
  output logic                          mosi,
  input  logic                          miso,
  output logic                          csn_active,
  output logic [C_SPI_SEL_WIDTH-1:0]    csn
);
  localparam int AW = C_CSR_ADDR_WIDTH;
  localparam int SW = C_SPI_SEL_WIDTH;
  localparam logic [SW-1:0] CSN_IDLE = (C_SPI_SEL_MODE == 0) ? {SW{1'b1}} : {SW{1'b0}};

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state;

  logic [31:0]   prof [16];
  logic [63:0]   tx, rx, sh, rxsh, rx_nxt;
  logic          done, lb, in_bit, samp, cmd_go, prof_wr, prof_rd;
  logic [7:0]    div, cnt;
  logic          cpol, cpha;
  logic [5:0]    nb;
  logic [6:0]    ecnt, sh_amt;
  logic [31:0]   p, rd;
  logic [SW-1:0] p_idx, csn_sel;
  logic [AW-3:0] wa, ra;
  logic          unused;

  assign csr_bresp = 2'b00;
  assign csr_rresp = 2'b00;
  assign wa = csr_awaddr[AW-1:2];
  assign ra = csr_araddr[AW-1:2];
  assign unused = ^{csr_awprot, csr_arprot, csr_awaddr[1:0], csr_araddr[1:0]};

`ifdef PIRADSPI_LOOPBACK_EN
  assign in_bit = lb ? mosi : miso;
`else
  assign lb     = 1'b0;
  assign in_bit = miso;
`endif

  function automatic logic [31:0] wmask(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  assign prof_wr = (csr_awaddr[AW-1:6] == (AW-6)'(1)) && ({1'b0, csr_awaddr[5:2]} < 5'(C_NUM_PROFILES));
  assign prof_rd = (csr_araddr[AW-1:6] == (AW-6)'(1));
  assign cmd_go  = csr_awready && (wa == (AW-2)'(2)) && (state == IDLE) &&
                   ({1'b0, csr_wdata[3:0]} < 5'(C_NUM_PROFILES));
  assign p       = prof[csr_wdata[3:0]];
  assign p_idx   = p[24 +: SW];
  // Without cpha the first bit goes straight onto mosi at SETUP, so skip it in the shifter.
  assign sh_amt  = 7'd63 - {1'b0, p[15:10]} + {6'd0, ~p[9]};
  assign samp    = ~ecnt[0] ^ cpha;
  assign rx_nxt  = {rxsh[62:0], in_bit};

  always_comb begin
    csn_sel = CSN_IDLE;
    if (C_SPI_SEL_MODE == 0) begin
      for (int i = 0; i < SW; i++) if (p_idx == SW'(i)) csn_sel[i] = 1'b0;
    end else csn_sel = p_idx;
  end

  always_comb begin
    rd = '0;
    if (prof_rd) rd = prof[csr_araddr[5:2]];
    else case (ra)
      (AW-2)'(0): rd = 32'h5052_5350;
      (AW-2)'(1): rd = {29'd0, lb, done, state != IDLE};
      (AW-2)'(4): rd = tx[31:0];
      (AW-2)'(5): rd = tx[63:32];
      (AW-2)'(6): rd = rx[31:0];
      (AW-2)'(7): rd = rx[63:32];
      default:    rd = '0;
    endcase
  end

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      csr_arready <= 1'b0;
      csr_rvalid  <= 1'b0;
      csr_rdata   <= '0;
    end else begin
      csr_arready <= csr_arvalid && !csr_rvalid && !csr_arready;
      if (csr_rvalid && csr_rready) csr_rvalid <= 1'b0;
      if (csr_arready) begin
        csr_rvalid <= 1'b1;
        csr_rdata  <= rd;
      end
    end
  end

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      csr_awready <= 1'b0; csr_wready <= 1'b0; csr_bvalid <= 1'b0;
      for (int i = 0; i < 16; i++) prof[i] <= '0;
      tx <= '0; rx <= '0; sh <= '0; rxsh <= '0; done <= 1'b0;
`ifdef PIRADSPI_LOOPBACK_EN
      lb <= 1'b0;
`endif
      div <= '0; cnt <= '0; cpol <= 1'b0; cpha <= 1'b0; nb <= '0; ecnt <= '0;
      sclk <= 1'b0; mosi <= 1'b0; csn_active <= 1'b0; csn <= CSN_IDLE;
      state <= IDLE;
    end else begin
      csr_awready <= csr_awvalid && csr_wvalid && !csr_bvalid && !csr_awready;
      csr_wready  <= csr_awvalid && csr_wvalid && !csr_bvalid && !csr_awready;
      if (csr_bvalid && csr_bready) csr_bvalid <= 1'b0;
      if (csr_awready) begin
        csr_bvalid <= 1'b1;
        if (wa == (AW-2)'(4)) tx[31:0]  <= wmask(tx[31:0], csr_wdata, csr_wstrb);
        if (wa == (AW-2)'(5)) tx[63:32] <= wmask(tx[63:32], csr_wdata, csr_wstrb);
        if (wa == (AW-2)'(1) && csr_wstrb[0]) begin
          if (csr_wdata[1]) done <= 1'b0;
`ifdef PIRADSPI_LOOPBACK_EN
          lb <= csr_wdata[2];
`endif
        end
        if (prof_wr) prof[csr_awaddr[5:2]] <= wmask(prof[csr_awaddr[5:2]], csr_wdata, csr_wstrb);
      end

      case (state)
        IDLE: if (cmd_go) begin
          div <= p[7:0]; cpol <= p[8]; cpha <= p[9]; nb <= p[15:10];
          cnt <= '0; ecnt <= '0; rxsh <= '0;
          sclk <= p[8];
          sh <= tx << sh_amt;
          if (!p[9]) mosi <= tx[p[15:10]];
          csn_active <= 1'b1;
          csn <= csn_sel;
          state <= SETUP;
        end
        default: begin
          if (cnt != div) cnt <= cnt + 8'd1;
          else begin
            cnt <= '0;
            if (state == HOLD) begin
              state <= IDLE; csn_active <= 1'b0; csn <= CSN_IDLE; done <= 1'b1;
            end else begin
              // Odd edge counts are trailing edges; the last one closes SHIFT.
              sclk <= ~sclk;
              ecnt <= ecnt + 7'd1;
              if (samp) rxsh <= rx_nxt;
              else begin
                mosi <= sh[63];
                sh   <= {sh[62:0], 1'b0};
              end
              if (state == SETUP) state <= SHIFT;
              else if (ecnt == {nb, 1'b1}) begin
                state <= HOLD;
                rx <= samp ? rx_nxt : rxsh;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piradspi_core.sv
// Self-checking bench for piradspi_core: CSR table vectors, directed SPI transfers and randomized transfers
// against a behavioural SPI slave that derives expected bits straight from the mode rules.
module tb_piradspi_core;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic sclk, mosi, miso = 1'b0, csn_active;
  logic [4:0] csn;

  always #5 clk = ~clk;

  piradspi_core dut (
    .csr_aclk(clk), .csr_areset(rst),
    .csr_awaddr(awaddr), .csr_awprot(awprot), .csr_awvalid(awvalid), .csr_awready(awready),
    .csr_wdata(wdata), .csr_wstrb(wstrb), .csr_wvalid(wvalid), .csr_wready(wready),
    .csr_bresp(bresp), .csr_bvalid(bvalid), .csr_bready(bready),
    .csr_araddr(araddr), .csr_arprot(arprot), .csr_arvalid(arvalid), .csr_arready(arready),
    .csr_rdata(rdata), .csr_rresp(rresp), .csr_rvalid(rvalid), .csr_rready(rready),
    .sclk(sclk), .mosi(mosi), .miso(miso), .csn_active(csn_active), .csn(csn)
  );

  int nerr = 0, nchk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural SPI slave and bus monitor, sampled on the falling clock edge.
  bit        m_cpol, m_cpha;
  int        m_nb = 8, s_pos, pulses, sel_cnt = 0, csn_err;
  logic [63:0] s_out;
  logic [4:0]  exp_csn;
  longint    t_last, hp_min, hp_max;
  bit        mosi_q[$];
  logic      p_act = 1'b0, p_sclk = 1'b0;

  task automatic hp_upd();
    longint d;
    d = $time - t_last;
    if (d < hp_min) hp_min = d;
    if (d > hp_max) hp_max = d;
    t_last = $time;
  endtask

  always @(negedge clk) begin
    bit lead;
    if (rst) begin
      p_act = 1'b0;
    end else begin
      if (csn_active && !p_act) begin
        sel_cnt++;
        s_pos = m_nb - 1;
        miso = m_cpha ? 1'b0 : s_out[s_pos];
        t_last = $time;
        if (csn !== exp_csn) csn_err++;
      end else if (csn_active && sclk != p_sclk) begin
        hp_upd();
        if (csn !== exp_csn) csn_err++;
        lead = (sclk != m_cpol);
        if (lead) pulses++;
        if (lead ^ m_cpha) mosi_q.push_back(mosi);
        else if (m_cpha) begin
          miso = (s_pos >= 0) ? s_out[s_pos] : 1'b0;
          s_pos--;
        end else begin
          s_pos--;
          miso = (s_pos >= 0) ? s_out[s_pos] : 1'b0;
        end
      end else if (!csn_active && p_act) hp_upd();
      p_act = csn_active;
    end
    p_sclk = sclk;
  end

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hf);
    int t;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    t = 0;
    while (!(awready && wready) && t < 50) begin @(posedge clk); #1; t++; end
    if (!(awready && wready)) begin nchk++; nerr++; $display("FAIL wr_timeout %h: awready=%b required 1", a, awready); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    t = 0;
    while (!bvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (!bvalid) begin nchk++; nerr++; $display("FAIL bvalid_timeout %h: bvalid=0 required 1", a); end
    else if (bresp !== 2'b00) begin nchk++; nerr++; $display("FAIL bresp %h: got %b required 00", a, bresp); end
    @(posedge clk); #1;
  endtask

  task automatic axi_rd(input logic [7:0] a, output logic [31:0] d);
    int t;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    t = 0;
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    if (!arready) begin nchk++; nerr++; $display("FAIL rd_timeout %h: arready=0 required 1", a); end
    @(posedge clk); #1;
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (!rvalid) begin nchk++; nerr++; $display("FAIL rvalid_timeout %h: rvalid=0 required 1", a); end
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(a, d);
    chk(nm, 64'(d), 64'(exp));
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int t = 0;
    st = 32'h1;
    while (st[0] && t < 2000) begin axi_rd(8'h04, st); t++; end
    if (st[0]) begin nchk++; nerr++; $display("FAIL busy_timeout: busy=1 required 0"); end
  endtask

  logic [63:0] last_mosi;

  task automatic run_xfer(input int pi, input int dv, input bit cp, input bit ch, input int nbits,
                          input int sidx, input logic [63:0] txv, input logic [63:0] sd, input bit lb);
    logic [31:0] pw, lo, hi, st;
    logic [63:0] mask, exp_rx, got;
    pw = (32'(sidx) << 24) | (32'(nbits - 1) << 10) | (32'(ch) << 9) | (32'(cp) << 8) | 32'(dv & 255);
    axi_wr(8'(8'h40 + 4 * pi), pw);
    axi_wr(8'h10, txv[31:0]);
    axi_wr(8'h14, txv[63:32]);
    m_cpol = cp; m_cpha = ch; m_nb = nbits; s_out = sd; exp_csn = 5'(sidx);
    mosi_q.delete(); pulses = 0; csn_err = 0; hp_min = 64'd1000000; hp_max = 0;
    axi_wr(8'h08, 32'(pi));
    wait_idle();
    mask = (nbits == 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    exp_rx = (lb ? txv : sd) & mask;
    axi_rd(8'h18, lo); axi_rd(8'h1C, hi);
    chk("rx", {hi, lo}, exp_rx);
    chk("pulses", 64'(pulses), 64'(nbits));
    got = '0;
    foreach (mosi_q[i]) got = {got[62:0], mosi_q[i]};
    last_mosi = got;
    chk("mosi_count", 64'(mosi_q.size()), 64'(nbits));
    chk("mosi_bits", got, txv & mask);
    chk("half_min", 64'(hp_min), 64'((dv + 1) * 10));
    chk("half_max", 64'(hp_max), 64'((dv + 1) * 10));
    chk("csn_err", 64'(csn_err), 64'd0);
    chk("sclk_idle", 64'(sclk), 64'(cp));
    chk("csn_inactive", 64'(csn_active), 64'd0);
    axi_rd(8'h04, st);
    chk("done_set", 64'(st[1:0]), 64'd2);
    axi_wr(8'h04, {29'd0, lb, 2'b10});
    axi_rd(8'h04, st);
    chk("done_w1c", 64'(st[1:0]), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    bit          do_wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  initial begin
    logic [31:0] d;
    int s0, t;
    vt.push_back('{8'h00, 0, 32'h0, 4'h0, 32'h5052_5350});
    vt.push_back('{8'h04, 0, 32'h0, 4'h0, 32'h0});
    vt.push_back('{8'h18, 0, 32'h0, 4'h0, 32'h0});
    vt.push_back('{8'h1C, 0, 32'h0, 4'h0, 32'h0});
    vt.push_back('{8'h40, 0, 32'h0, 4'h0, 32'h0});
    vt.push_back('{8'h10, 1, 32'hFFFF_FFFF, 4'h5, 32'h00FF_00FF});
    vt.push_back('{8'h14, 1, 32'h1234_5678, 4'hF, 32'h1234_5678});
    vt.push_back('{8'h7C, 1, 32'hAABB_CCDD, 4'h8, 32'hAA00_0000});
    vt.push_back('{8'h00, 1, 32'hFFFF_FFFF, 4'hF, 32'h5052_5350});
    vt.push_back('{8'h18, 1, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vt.push_back('{8'h80, 1, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vt.push_back('{8'h20, 1, 32'h5555_5555, 4'hF, 32'h0});
`ifdef PIRADSPI_LOOPBACK_EN
    vt.push_back('{8'h04, 1, 32'h0000_0004, 4'hF, 32'h4});
`else
    vt.push_back('{8'h04, 1, 32'h0000_0004, 4'hF, 32'h0});
`endif
    vt.push_back('{8'h04, 1, 32'h0000_0000, 4'hF, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_csn_active", 64'(csn_active), 64'd0);
    chk("rst_csn", 64'(csn), 64'd0);
    chk("rst_valids", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
    rst = 0;

    axi_rd(8'h00, d);
    chk("id", 64'(d), 64'h5052_5350);
    chk("id_rresp", 64'(rresp), 64'd0);
    foreach (vt[i]) begin
      if (vt[i].do_wr) axi_wr(vt[i].addr, vt[i].wdata, vt[i].wstrb);
      rd_chk($sformatf("vec%0d_%h", i, vt[i].addr), vt[i].addr, vt[i].exp);
    end

    // 64-bit cpol0/cpha0 exchange with a preset slave.
    run_xfer(0, 1, 0, 0, 64, 0, 64'hDEADBEEF_CAFEF00D, 64'h01020304_05060708, 0);
    // 8-bit cpol1/cpha1 on target 3, half-period 5 cycles.
    run_xfer(3, 4, 1, 1, 8, 3, 64'hA5, 64'h3C, 0);
    chk("mosi_seq_A5", last_mosi, 64'b10100101);

    // A second CMD while busy must not start another transfer.
    s0 = sel_cnt;
    axi_wr(8'h08, 32'd3);
    axi_wr(8'h08, 32'd0);
    wait_idle();
    chk("one_transfer", 64'(sel_cnt - s0), 64'd1);
    rd_chk("busy_done", 8'h04, 32'h2);
    axi_wr(8'h04, 32'h2);
    rd_chk("w1c_status", 8'h04, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_xfer($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom_range(1, 64), $urandom_range(0, 31),
               {$urandom, $urandom}, {$urandom, $urandom}, 0);
    end

`ifdef PIRADSPI_LOOPBACK_EN
    axi_wr(8'h04, 32'h4);
    run_xfer(5, 0, 0, 0, 16, 1, 64'h1234, 64'hFFFF, 1);
    run_xfer(6, 2, 1, 1, 24, 2, 64'hABCDEF, 64'h0, 1);
    axi_wr(8'h04, 32'h0);
`endif

    // Reset in the middle of SHIFT aborts the transfer.
    axi_wr(8'h48, (32'd5 << 24) | (32'd31 << 10) | 32'd3);
    m_cpol = 0; m_cpha = 0; m_nb = 32; exp_csn = 5'd5; pulses = 0;
    axi_wr(8'h08, 32'd2);
    t = 0;
    while (pulses < 4 && t < 2000) begin @(posedge clk); t++; end
    chk("mid_shift_reached", 64'(pulses >= 4), 64'd1);
    #1 rst = 1;
    #2;
    chk("abort_sclk", 64'(sclk), 64'd0);
    chk("abort_csn_active", 64'(csn_active), 64'd0);
    chk("abort_csn", 64'(csn), 64'd0);
    chk("abort_mosi", 64'(mosi), 64'd0);
    @(posedge clk); #1 rst = 0;
    rd_chk("abort_status", 8'h04, 32'h0);
    rd_chk("abort_rx_lo", 8'h18, 32'h0);
    rd_chk("abort_rx_hi", 8'h1C, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
